// File: rtl/cisc_ctrl_pkg.sv
// rtl/cisc_ctrl_pkg.sv - shared states, microwords and opcode codes for the CISC microsequencer
package cisc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_F_ADDR = 4'd0,
      S_F_WAIT = 4'd1,
      S_F_LOAD = 4'd2,
      S_DECODE = 4'd3,
      S_RR1    = 4'd4,
      S_RR2    = 4'd5,
      S_LD1    = 4'd6,
      S_LD2    = 4'd7,
      S_LD3    = 4'd8,
      S_ST1    = 4'd9,
      S_ST2    = 4'd10,
      S_JMP    = 4'd11,
      S_HALT   = 4'd12,
      S_FAULT  = 4'd13
   } state_t;

   localparam logic [1:0] CLS_MEM = 2'b11;
   localparam logic [1:0] SUB_LD  = 2'b00;
   localparam logic [1:0] SUB_ST  = 2'b01;
   localparam logic [1:0] SUB_JMP = 2'b10;

   localparam logic [15:0] CW_FETCH = 16'h5800;
   localparam logic [15:0] CW_IRLD  = 16'h0001;
   localparam logic [15:0] CW_RR1   = 16'hC1A0;
   localparam logic [15:0] CW_RR2   = 16'h01A0;
   localparam logic [15:0] CW_LD1   = 16'h1080;
   localparam logic [15:0] CW_LD2   = 16'h0600;
   localparam logic [15:0] CW_LD3   = 16'h0380;
   localparam logic [15:0] CW_ST1   = 16'h3080;
   localparam logic [15:0] CW_ST2   = 16'h0200;
   localparam logic [15:0] CW_JMP   = 16'h0880;

   function automatic logic [15:0] cw_of(state_t s);
      case (s)
         S_F_ADDR, S_F_WAIT: return CW_FETCH;
         S_F_LOAD:           return CW_IRLD;
         S_RR1:              return CW_RR1;
         S_RR2:              return CW_RR2;
         S_LD1:              return CW_LD1;
         S_LD2:              return CW_LD2;
         S_LD3:              return CW_LD3;
         S_ST1:              return CW_ST1;
         S_ST2:              return CW_ST2;
         S_JMP:              return CW_JMP;
         default:            return 16'h0000;
      endcase
   endfunction

   function automatic logic is_mem(state_t s);
      return s inside {S_F_ADDR, S_F_WAIT, S_LD1, S_ST1};
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts stalled memory cycles and flags the one that exhausts the budget
module mem_wait_timer #(
   parameter int WAIT_MAX = 16
) (
   input  logic clk1,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic timeout
);

   localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk1) begin
      if (reset || clr)
         cnt <= '0;
      else if (inc)
         cnt <= cnt + CW'(1);
   end

   // Fires on the stalled cycle that would bring the count up to WAIT_MAX.
   assign timeout = inc && (cnt == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/micro_seq_ctrl.sv
// rtl/micro_seq_ctrl.sv - fetch/decode/execute microsequencer driving the execution unit control word
module micro_seq_ctrl
   import cisc_ctrl_pkg::*;
#(
   parameter int WAIT_MAX = 16,
   parameter int CNT_W    = 16
) (
   input  logic             clk1,
   input  logic             reset,
   input  logic [7:0]       ire,
   input  logic             mem_rdy,
   input  logic             run,
   input  logic             halt_req,
   output logic [15:0]      cword,
   output logic             mem_req,
   output logic             mem_we,
   output logic             instr_done,
   output logic [CNT_W-1:0] instr_cnt,
   output logic             busy,
   output logic             halted,
   output logic             fault,
   output logic [3:0]       state
);

   state_t state_q, state_nxt, boundary;
   logic   timeout, done_nxt;
   logic   unused_ire;

   assign unused_ire = ^{ire[5:4], ire[1:0]};
   assign state      = state_q;

   // Every access starts from a non-request state, so a low mem_req clears the timer.
   mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
      .clk1    (clk1),
      .reset   (reset),
      .clr     (!mem_req),
      .inc     (mem_req && !mem_rdy),
      .timeout (timeout)
   );

   always_comb begin
      boundary  = halt_req ? S_HALT : S_F_ADDR;
      state_nxt = state_q;
      case (state_q)
         // busy low in F_ADDR means the idle cycle after reset: enter the fetch properly.
         S_F_ADDR: if (!busy)       state_nxt = S_F_ADDR;
                   else if (mem_rdy) state_nxt = S_F_LOAD;
                   else if (timeout) state_nxt = S_FAULT;
                   else              state_nxt = S_F_WAIT;
         S_F_WAIT: if (mem_rdy)      state_nxt = S_F_LOAD;
                   else if (timeout) state_nxt = S_FAULT;
         S_F_LOAD: state_nxt = S_DECODE;
         S_DECODE: if (ire[7:6] != CLS_MEM) state_nxt = S_RR1;
                   else case (ire[3:2])
                      SUB_LD:  state_nxt = S_LD1;
                      SUB_ST:  state_nxt = S_ST1;
                      SUB_JMP: state_nxt = S_JMP;
                      default: state_nxt = S_HALT;
                   endcase
         S_RR1:    state_nxt = S_RR2;
         S_LD1:    if (mem_rdy)      state_nxt = S_LD2;
                   else if (timeout) state_nxt = S_FAULT;
         S_LD2:    state_nxt = S_LD3;
         S_ST1:    if (mem_rdy)      state_nxt = S_ST2;
                   else if (timeout) state_nxt = S_FAULT;
         S_RR2, S_LD3, S_ST2, S_JMP: state_nxt = boundary;
         S_HALT:   if (run) state_nxt = S_F_ADDR;
         S_FAULT:  state_nxt = S_FAULT;
         default:  state_nxt = S_F_ADDR;
      endcase
      done_nxt = (state_nxt inside {S_RR2, S_LD3, S_ST2, S_JMP}) ||
                 (state_nxt == S_HALT && state_q != S_HALT);
   end

   always_ff @(posedge clk1) begin
      if (reset) begin
         state_q    <= S_F_ADDR;
         cword      <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         instr_done <= 1'b0;
         instr_cnt  <= '0;
         busy       <= 1'b0;
         halted     <= 1'b0;
         fault      <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         cword      <= cw_of(state_nxt);
         mem_req    <= is_mem(state_nxt);
         mem_we     <= (state_nxt == S_ST1);
         instr_done <= done_nxt;
         if (done_nxt)
            instr_cnt <= instr_cnt + CNT_W'(1);
         busy       <= !(state_nxt inside {S_HALT, S_FAULT});
         halted     <= (state_nxt == S_HALT);
         fault      <= (state_nxt == S_FAULT);
      end
   end

endmodule

// File: tb/tb_micro_seq_ctrl.sv
// tb/tb_micro_seq_ctrl.sv - self-checking bench: per-cycle expectations expanded from instruction-level rules
module tb_micro_seq_ctrl;

   localparam int WAIT_MAX = 4;
   localparam int CNT_W    = 8;
   localparam int OW       = 22 + CNT_W;

   logic             clk1 = 1'b0;
   logic             reset = 1'b1;
   logic [7:0]       ire = 8'h00;
   logic             mem_rdy = 1'b0, run = 1'b0, halt_req = 1'b0;
   logic [15:0]      cword;
   logic             mem_req, mem_we, instr_done, busy, halted, fault;
   logic [CNT_W-1:0] instr_cnt;
   logic [3:0]       state;
   logic [OW-1:0]    dut_obs;

   micro_seq_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
      .clk1(clk1), .reset(reset), .ire(ire), .mem_rdy(mem_rdy), .run(run), .halt_req(halt_req),
      .cword(cword), .mem_req(mem_req), .mem_we(mem_we), .instr_done(instr_done),
      .instr_cnt(instr_cnt), .busy(busy), .halted(halted), .fault(fault), .state(state)
   );

   always #5 clk1 = ~clk1;

   assign dut_obs = {cword, mem_req, mem_we, instr_done, instr_cnt, busy, halted, fault};

   typedef struct packed {
      logic [7:0]       ire;
      logic             rdy, hreq, run;
      logic [15:0]      cw;
      logic             req, we, done;
      logic [CNT_W-1:0] cnt;
      logic             busy, halted, fault;
   } vec_t;

   vec_t q[$];
   int   model_cnt;
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic coin();
      return $urandom_range(0, 1) == 1;
   endfunction

   function automatic logic [7:0] rbyte();
      return 8'($urandom);
   endfunction

   // One expected cycle: inputs to drive during it and outputs it must show.
   function automatic void push(logic [7:0] i, logic r, logic h, logic u, logic [15:0] cw,
                                logic rq, logic we, logic dn, logic hl, logic ft);
      vec_t v;
      if (dn) model_cnt = (model_cnt + 1) % (1 << CNT_W);
      v.ire = i; v.rdy = r; v.hreq = h; v.run = u;
      v.cw = cw; v.req = rq; v.we = we; v.done = dn;
      v.cnt = CNT_W'(model_cnt);
      v.busy = !hl && !ft; v.halted = hl; v.fault = ft;
      q.push_back(v);
   endfunction

   // Memory access stalled for 'waits' cycles; returns 1 when the stall exhausts the budget.
   function automatic bit access(logic [15:0] cw, logic we, int waits);
      int n = (waits >= WAIT_MAX) ? WAIT_MAX : waits;
      for (int k = 0; k < n; k++) push(rbyte(), 1'b0, coin(), coin(), cw, 1'b1, we, 1'b0, 1'b0, 1'b0);
      if (waits >= WAIT_MAX) return 1'b1;
      push(rbyte(), 1'b1, coin(), coin(), cw, 1'b1, we, 1'b0, 1'b0, 1'b0);
      return 1'b0;
   endfunction

   function automatic void halt_cycles(int delay);
      for (int k = 0; k <= delay; k++)
         push(rbyte(), coin(), (k == delay) ? 1'b1 : coin(), k == delay, 16'h0000,
              1'b0, 1'b0, k == 0, 1'b1, 1'b0);
   endfunction

   function automatic void fault_cycles(int n);
      for (int k = 0; k < n; k++)
         push(rbyte(), coin(), coin(), coin(), 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endfunction

   // Whole instruction; hb requests a halt at its boundary, hd is cycles before run rises.
   function automatic bit push_instr(logic [7:0] op, int wf, int wm, bit hb, int hd);
      logic dn_h;
      dn_h = hb;
      if (access(16'h5800, 1'b0, wf)) return 1'b1;
      push(rbyte(), coin(), coin(), coin(), 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push(op,      coin(), coin(), coin(), 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (op[7:6] != 2'b11) begin
         push(rbyte(), coin(), coin(), coin(), 16'hC1A0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         push(rbyte(), coin(), dn_h,   coin(), 16'h01A0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end else begin
         case (op[3:2])
            2'b00: begin
               if (access(16'h1080, 1'b0, wm)) return 1'b1;
               push(rbyte(), coin(), coin(), coin(), 16'h0600, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
               push(rbyte(), coin(), dn_h,   coin(), 16'h0380, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            2'b01: begin
               if (access(16'h3080, 1'b1, wm)) return 1'b1;
               push(rbyte(), coin(), dn_h, coin(), 16'h0200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            2'b10: push(rbyte(), coin(), dn_h, coin(), 16'h0880, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            default: begin
               halt_cycles(hd);
               return 1'b0;
            end
         endcase
      end
      if (hb) halt_cycles(hd);
      return 1'b0;
   endfunction

   task automatic check(input string nm, input int idx, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc %0d: got %h expected %h (cword=%h vs %h; fields cword/req/we/done/cnt/busy/halted/fault)",
                  nm, idx, got, exp, got[OW-1 -: 16], exp[OW-1 -: 16]);
      end
   endtask

   // Reset, check reset values, then replay the queued cycles.
   task automatic run_seg(input string nm);
      reset = 1'b1; mem_rdy = 1'b1; run = coin(); halt_req = coin(); ire = rbyte();
      @(posedge clk1); #1;
      check({nm, "/reset"}, -1, dut_obs, '0);
      reset = 1'b0;
      mem_rdy = coin();
      for (int i = 0; i < q.size(); i++) begin
         @(posedge clk1); #1;
         check(nm, i, dut_obs, {q[i].cw, q[i].req, q[i].we, q[i].done, q[i].cnt,
                                q[i].busy, q[i].halted, q[i].fault});
         ire = q[i].ire; mem_rdy = q[i].rdy; halt_req = q[i].hreq; run = q[i].run;
      end
   endtask

   initial begin
      bit f;

      // Zero-wait RR instruction, written out cycle by cycle.
      model_cnt = 0; q.delete();
      q.push_back('{8'h12, 1'b1, 1'b0, 1'b0, 16'h5800, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0});
      q.push_back('{8'h00, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0});
      q.push_back('{8'h12, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0});
      q.push_back('{8'h00, 1'b0, 1'b0, 1'b0, 16'hC1A0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0});
      q.push_back('{8'h00, 1'b0, 1'b0, 1'b0, 16'h01A0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0});
      q.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 16'h5800, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0});
      run_seg("rr_table");

      model_cnt = 0; q.delete();
      f = push_instr(8'h12, 3, 0, 1'b0, 0);
      run_seg("fetch_wait");

      model_cnt = 0; q.delete();
      f = push_instr(8'h12, WAIT_MAX, 0, 1'b0, 0);
      fault_cycles(6);
      run_seg("fetch_timeout");

      model_cnt = 0; q.delete();
      f = push_instr(8'h6D, 0, 0, 1'b0, 0);
      f = push_instr(8'hC1, 1, WAIT_MAX, 1'b0, 0);
      fault_cycles(5);
      run_seg("ld_timeout");

      model_cnt = 0; q.delete();
      f = push_instr(8'hC4, 0, 2, 1'b0, 0);
      f = push_instr(8'hE3, 1, 1, 1'b0, 0);
      f = push_instr(8'hD9, 0, 0, 1'b0, 0);
      f = push_instr(8'h4B, 0, 0, 1'b1, 2);
      f = push_instr(8'hCC, 0, 0, 1'b0, 0);
      f = push_instr(8'h87, 2, 0, 1'b1, 0);
      f = push_instr(8'hF6, 0, 3, 1'b0, 0);
      run_seg("mix");

      // Stop mid-LD1 so the next reset lands on a pending access.
      model_cnt = 0; q.delete();
      f = access(16'h5800, 1'b0, 0);
      push(rbyte(), coin(), coin(), coin(), 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push(8'hC2,   coin(), coin(), coin(), 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push(rbyte(), 1'b0,   coin(), coin(), 16'h1080, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      push(rbyte(), 1'b0,   coin(), coin(), 16'h1080, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_seg("ld1_reset");

      model_cnt = 0; q.delete();
      for (int n = 0; n < 260; n++) f = push_instr(8'hC8 | (rbyte() & 8'h33), 0, 0, 1'b0, 0);
      run_seg("cnt_wrap");

      for (int s = 0; s < 6; s++) begin
         model_cnt = 0; q.delete();
         for (int n = 0; n < 40; n++) begin
            int wf, wm;
            wf = ($urandom_range(0, 49) == 0) ? WAIT_MAX : $urandom_range(0, WAIT_MAX - 1);
            wm = ($urandom_range(0, 29) == 0) ? WAIT_MAX : $urandom_range(0, WAIT_MAX - 1);
            if (push_instr(rbyte(), wf, wm, $urandom_range(0, 5) == 0, $urandom_range(0, 3))) begin
               fault_cycles(3);
               break;
            end
         end
         run_seg($sformatf("rand%0d", s));
      end

      model_cnt = 0; q.delete();
      run_seg("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
